// File: rtl/key_press_classifier_if.sv
// Key/event bundle between a key source and the press classifier.
// The classifier takes the slave side; whoever drives the key takes the master side.
interface key_press_classifier_if;
  logic       key_level;
  logic       short_pulse;
  logic       long_pulse;
  logic       double_pulse;
  logic [7:0] press_cnt;
  logic       busy;

  modport master (
    output key_level,
    input  short_pulse,
    input  long_pulse,
    input  double_pulse,
    input  press_cnt,
    input  busy
  );

  modport slave (
    input  key_level,
    output short_pulse,
    output long_pulse,
    output double_pulse,
    output press_cnt,
    output busy
  );
endinterface

// File: rtl/key_press_classifier.sv
// Classifies a debounced key into short, long and double presses and keeps a
// running press score. All outputs are registered.
module key_press_classifier #(
  parameter int LONG_MS    = 1000,
  parameter int DBL_GAP_MS = 300,
  parameter int CNT_W      = 11
) (
  input  logic                  clk_out,
  input  logic                  timer_rst,
  key_press_classifier_if.slave kp
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             short_evt;
  logic             long_evt;
  logic             double_evt;
  logic             short_q;
  logic             long_q;
  logic             double_q;
  logic             busy_q;
  logic [7:0]       press_cnt_q;

  // A key press during the last gap cycle still wins over the short timeout.
  always_comb begin
    next_state = state;
    short_evt  = 1'b0;
    long_evt   = 1'b0;
    double_evt = 1'b0;
    case (state)
      IDLE: begin
        if (kp.key_level) next_state = PRESS1;
      end
      PRESS1: begin
        if (!kp.key_level) begin
          next_state = WAIT2;
        end else if (cnt == LONG_LAST) begin
          next_state = LONG_HOLD;
          long_evt   = 1'b1;
        end
      end
      WAIT2: begin
        if (kp.key_level) begin
          next_state = PRESS2;
        end else if (cnt == GAP_LAST) begin
          next_state = IDLE;
          short_evt  = 1'b1;
        end
      end
      PRESS2: begin
        if (!kp.key_level) begin
          next_state = IDLE;
          double_evt = 1'b1;
        end else if (cnt == LONG_LAST) begin
          next_state = LONG_HOLD;
          double_evt = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (!kp.key_level) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter restarts on each state change; busy tracks the state being loaded.
  always_ff @(posedge clk_out or posedge timer_rst) begin
    if (timer_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      double_q    <= 1'b0;
      busy_q      <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state    <= next_state;
      short_q  <= short_evt;
      long_q   <= long_evt;
      double_q <= double_evt;
      busy_q   <= (next_state != IDLE);
      if (next_state != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_ONE;
      end
      if (long_evt) begin
        press_cnt_q <= 8'd0;
      end else if (double_evt) begin
        press_cnt_q <= press_cnt_q + 8'd2;
      end else if (short_evt) begin
        press_cnt_q <= press_cnt_q + 8'd1;
      end
    end
  end

  assign kp.short_pulse  = short_q;
  assign kp.long_pulse   = long_q;
  assign kp.double_pulse = double_q;
  assign kp.busy         = busy_q;
  assign kp.press_cnt    = press_cnt_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomized and directed bench for key_press_classifier: a run-length reference
// model fills a scoreboard that a negedge monitor drains as events appear.
module tb_key_press_classifier;

  localparam int LONG_MS    = 1000;
  localparam int DBL_GAP_MS = 300;
  localparam int K_SHORT    = 0;
  localparam int K_LONG     = 1;
  localparam int K_DOUBLE   = 2;

  typedef struct {
    int         edge_idx;
    int         kind;
    logic [7:0] cnt;
  } exp_t;

  logic clk_out   = 1'b0;
  logic timer_rst = 1'b1;

  key_press_classifier_if kp_bus ();

  key_press_classifier #(
    .LONG_MS   (LONG_MS),
    .DBL_GAP_MS(DBL_GAP_MS),
    .CNT_W     (11)
  ) dut (
    .clk_out  (clk_out),
    .timer_rst(timer_rst),
    .kp       (kp_bus)
  );

  always #5 clk_out = ~clk_out;

  int         errors = 0;
  int         checks = 0;
  int         posedge_cnt = 0;
  int         base = 0;
  bit         stim[$];
  exp_t       sb[$];
  logic [7:0] model_cnt = 8'd0;

  always @(posedge clk_out) posedge_cnt <= posedge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int runLen(input int i);
    int j = i;
    while (j < stim.size() && stim[j] == stim[i]) j++;
    return j - i;
  endfunction

  function automatic void pushEvent(input int e, input int k);
    exp_t x;
    x.edge_idx = e;
    x.kind     = k;
    x.cnt      = model_cnt;
    sb.push_back(x);
  endfunction

  // Walks the key waveform as runs of highs and lows and predicts every event.
  function automatic void buildExpected();
    int n = stim.size();
    int i = 0;
    int s, h, r, gap, p, h2;
    while (i < n) begin
      if (!stim[i]) begin
        i++;
        continue;
      end
      s = i;
      h = runLen(s);
      if (h >= LONG_MS + 1) begin
        model_cnt = 8'd0;
        pushEvent(s + LONG_MS, K_LONG);
        if (s + h >= n) break;
        i = s + h + 1;
        continue;
      end
      if (s + h >= n) break;
      r   = s + h;
      gap = runLen(r);
      if (gap >= DBL_GAP_MS + 1) begin
        model_cnt = model_cnt + 8'd1;
        pushEvent(r + DBL_GAP_MS, K_SHORT);
        i = r + DBL_GAP_MS + 1;
        continue;
      end
      if (r + gap >= n) break;
      p  = r + gap;
      h2 = runLen(p);
      if (h2 >= LONG_MS + 1) begin
        model_cnt = model_cnt + 8'd2;
        pushEvent(p + LONG_MS, K_DOUBLE);
        if (p + h2 >= n) break;
        i = p + h2 + 1;
        continue;
      end
      if (p + h2 >= n) break;
      model_cnt = model_cnt + 8'd2;
      pushEvent(p + h2, K_DOUBLE);
      i = p + h2 + 1;
    end
  endfunction

  task automatic addRun(input bit lvl, input int len);
    for (int k = 0; k < len; k++) stim.push_back(lvl);
  endtask

  // Drives stim one sample per clock from IDLE; optionally verifies the drained end state.
  task automatic applyStimulus(input bit final_check);
    buildExpected();
    @(negedge clk_out);
    base = posedge_cnt;
    for (int i = 0; i < stim.size(); i++) begin
      kp_bus.key_level = stim[i];
      @(negedge clk_out);
      if (i == 0 && stim[0]) checkOutput("busy_after_first_press", int'(kp_bus.busy), 1);
    end
    if (final_check) begin
      kp_bus.key_level = 1'b0;
      @(negedge clk_out);
      #1;
      checkOutput("events_pending", sb.size(), 0);
      checkOutput("busy_idle", int'(kp_bus.busy), 0);
      checkOutput("press_cnt_end", int'(kp_bus.press_cnt), int'(model_cnt));
      sb.delete();
    end
    stim.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_short"}, int'(kp_bus.short_pulse), 0);
    checkOutput({tag, "_long"}, int'(kp_bus.long_pulse), 0);
    checkOutput({tag, "_double"}, int'(kp_bus.double_pulse), 0);
    checkOutput({tag, "_busy"}, int'(kp_bus.busy), 0);
    checkOutput({tag, "_press_cnt"}, int'(kp_bus.press_cnt), 0);
  endtask

  task automatic doReset();
    @(negedge clk_out);
    kp_bus.key_level = 1'b0;
    timer_rst = 1'b1;
    #1;
    checkAllZero("reset");
    model_cnt = 8'd0;
    sb.delete();
    repeat (3) @(negedge clk_out);
    timer_rst = 1'b0;
  endtask

  function automatic int randHigh();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(1, 80));
    return int'($urandom_range(995, 1005));
  endfunction

  function automatic int randLow();
    int sel = int'($urandom_range(0, 9));
    if (sel < 5) return int'($urandom_range(1, 100));
    if (sel < 8) return int'($urandom_range(297, 303));
    return int'($urandom_range(1, 5));
  endfunction

  logic [2:0] mon_pulses;
  int         mon_idx;
  int         mon_kind;
  exp_t       mon_e;

  // Every pulse seen must match the oldest predicted event in kind, cycle and score.
  always @(negedge clk_out) begin
    if (!timer_rst) begin
      mon_pulses = {kp_bus.short_pulse, kp_bus.long_pulse, kp_bus.double_pulse};
      if (mon_pulses != 3'b000) begin
        mon_idx  = posedge_cnt - base - 1;
        mon_kind = kp_bus.short_pulse ? K_SHORT : (kp_bus.long_pulse ? K_LONG : K_DOUBLE);
        checkOutput("one_pulse_at_a_time", $countones(mon_pulses), 1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_event_kind", mon_kind, -1);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("event_kind", mon_kind, mon_e.kind);
          checkOutput("event_cycle", mon_idx, mon_e.edge_idx);
          checkOutput("event_press_cnt", int'(kp_bus.press_cnt), int'(mon_e.cnt));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    kp_bus.key_level = 1'b0;
    #1;
    checkAllZero("power_on");
    doReset();

    // Short press, then double press.
    addRun(0, 5); addRun(1, 100); addRun(0, 320);
    applyStimulus(1'b1);
    checkOutput("short_score", int'(kp_bus.press_cnt), 1);
    addRun(1, 50); addRun(0, 100); addRun(1, 50); addRun(0, 320);
    applyStimulus(1'b1);
    checkOutput("double_score", int'(kp_bus.press_cnt), 3);

    // Reset arriving deep into a held press discards it; the held key restarts.
    addRun(0, 5); addRun(1, 501);
    applyStimulus(1'b0);
    checkOutput("busy_before_reset", int'(kp_bus.busy), 1);
    #2;
    timer_rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    model_cnt = 8'd0;
    sb.delete();
    repeat (3) @(negedge clk_out);
    timer_rst = 1'b0;
    addRun(1, 30); addRun(0, 320);
    applyStimulus(1'b1);

    // Long press with a late release.
    addRun(1, 1500); addRun(0, 320);
    applyStimulus(1'b1);
    checkOutput("long_score", int'(kp_bus.press_cnt), 0);

    // Second press exactly on the last gap cycle, then one cycle too late.
    addRun(1, 20); addRun(0, 300); addRun(1, 10); addRun(0, 320);
    applyStimulus(1'b1);
    addRun(1, 20); addRun(0, 301); addRun(1, 10); addRun(0, 320);
    applyStimulus(1'b1);

    // Score wrap: 254+2 -> 0, then 254 -> 255 via a short, then +2 -> 1.
    doReset();
    for (int k = 0; k < 128; k++) begin
      addRun(1, 1); addRun(0, 1); addRun(1, 1); addRun(0, 1);
    end
    for (int k = 0; k < 127; k++) begin
      addRun(1, 1); addRun(0, 1); addRun(1, 1); addRun(0, 1);
    end
    addRun(1, 1); addRun(0, 302);
    addRun(1, 1); addRun(0, 1); addRun(1, 1); addRun(0, 320);
    applyStimulus(1'b1);
    checkOutput("wrap_score", int'(kp_bus.press_cnt), 1);

    for (int sc = 0; sc < 4; sc++) begin
      for (int k = 0; k < 10; k++) begin
        addRun(1, randHigh());
        addRun(0, randLow());
      end
      addRun(0, 320);
      applyStimulus(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
